// File: rtl/fb_pkg.sv
//------------------------------------------------------------------------------
// Module   : fb_pkg
// Purpose  : Shared frame-buffer geometry, address/pixel types and arbiter states.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fb_pkg;

   localparam int FB_WIDTH  = 320;
   localparam int FB_HEIGHT = 240;
   localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;
   localparam int FB_ADDR_W = 17;

   typedef logic [23:0]          pixel_t;
   typedef logic [FB_ADDR_W-1:0] fb_addr_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PREFETCH = 2'd1,
      DRAIN    = 2'd2
   } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/fb_wr_fifo.sv
//------------------------------------------------------------------------------
// Module   : fb_wr_fifo
// Purpose  : Small synchronous show-ahead FIFO buffering bus pixel writes.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fb_wr_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 41
) (
   input  logic             clk_50,
   input  logic             n_rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   import fb_pkg::*;

   localparam int                 c_ptr_w = $clog2(DEPTH);
   localparam logic [c_ptr_w:0]   c_full  = DEPTH[c_ptr_w:0];

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_ptr_w-1:0] r_wr_ptr;
   logic [c_ptr_w-1:0] r_rd_ptr;
   logic [c_ptr_w:0]   r_count;
   logic               w_do_push;
   logic               w_do_pop;

   assign full      = (r_count == c_full);
   assign empty     = (r_count == '0);
   assign w_do_pop  = pop && !empty;
   // a pop in the same cycle frees the slot, so a full FIFO may still accept
   assign w_do_push = push && (!full || w_do_pop);
   assign dout      = r_mem[r_rd_ptr];

   always_ff @(posedge clk_50 or negedge n_rst) begin
      if (!n_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (c_ptr_w + 1)'(1);
            2'b01:   r_count <= r_count - (c_ptr_w + 1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk_50) begin
      if (w_do_push) r_mem[r_wr_ptr] <= din;
   end

endmodule

`default_nettype wire

// File: rtl/fb_mem_arbiter.sv
//------------------------------------------------------------------------------
// Module   : fb_mem_arbiter
// Purpose  : Shares the frame-buffer SRAM between buffered bus writes and
//            display scanline prefetch (prefetch has priority).
//            Option macro FB_WRITE_SLOT_EN: lets a full write FIFO steal one
//            slot per 16 columns during prefetch.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fb_mem_arbiter #(
   parameter int FB_WIDTH    = fb_pkg::FB_WIDTH,
   parameter int FB_HEIGHT   = fb_pkg::FB_HEIGHT,
   parameter int ADDR_W      = fb_pkg::FB_ADDR_W,
   parameter int DATA_W      = 24,
   parameter int WFIFO_DEPTH = 4
) (
   input  logic              clk_50,
   input  logic              n_rst,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              line_req,
   input  logic [7:0]        line_y,
   output logic              lb_wen,
   output logic [8:0]        lb_waddr,
   output logic [DATA_W-1:0] lb_wdata,
   output logic              line_done,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              overrun
);
   import fb_pkg::*;

   localparam int         c_fifo_w   = ADDR_W + DATA_W;
   localparam logic [8:0] c_last_col = 9'(FB_WIDTH - 1);

   arb_state_t          r_state;
   arb_state_t          w_state_nxt;
   logic [ADDR_W-1:0]   r_base;
   logic [ADDR_W-1:0]   w_base_nxt;
   logic [ADDR_W-1:0]   w_line_base;
   logic [8:0]          r_col;
   logic [8:0]          w_col_nxt;
   logic                r_overrun;
   logic                r_rd_vld;
   logic [8:0]          r_rd_col;
   logic                r_rd_last;
   logic                w_rd_issue;
   logic                w_rd_last;
   logic                w_req_ok;
   logic                w_slot;
   logic                w_fifo_push;
   logic                w_fifo_pop;
   logic                w_fifo_full;
   logic                w_fifo_empty;
   logic [c_fifo_w-1:0] w_fifo_din;
   logic [c_fifo_w-1:0] w_fifo_dout;

   assign w_fifo_push = wr_valid && wr_ready;
   assign w_fifo_din  = {wr_addr, wr_data};
   assign wr_ready    = !w_fifo_full;

   fb_wr_fifo #(
      .DEPTH (WFIFO_DEPTH),
      .WIDTH (c_fifo_w)
   ) u_wr_fifo (
      .clk_50 (clk_50),
      .n_rst  (n_rst),
      .push   (w_fifo_push),
      .pop    (w_fifo_pop),
      .din    (w_fifo_din),
      .dout   (w_fifo_dout),
      .full   (w_fifo_full),
      .empty  (w_fifo_empty)
   );

   generate
      if (FB_WIDTH == 320) begin : g_base_shift
         assign w_line_base = (ADDR_W'(line_y) << 8) + (ADDR_W'(line_y) << 6);
      end else begin : g_base_mult
         assign w_line_base = ADDR_W'(int'(line_y) * FB_WIDTH);
      end
   endgenerate

   assign w_req_ok = line_req && (int'(line_y) < FB_HEIGHT);

`ifdef FB_WRITE_SLOT_EN
   // one write slot is offered ahead of each 16-column group, at most once
   logic r_slot_used;

   assign w_slot = (r_state == PREFETCH) && (r_col[3:0] == 4'd0) &&
                   !r_slot_used && w_fifo_full;

   always_ff @(posedge clk_50 or negedge n_rst) begin
      if (!n_rst)                    r_slot_used <= 1'b0;
      else if (r_state != PREFETCH)  r_slot_used <= 1'b0;
      else if (w_slot)               r_slot_used <= 1'b1;
      else if (w_rd_issue)           r_slot_used <= 1'b0;
   end
`else
   assign w_slot = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_base_nxt  = r_base;
      w_col_nxt   = r_col;
      w_fifo_pop  = 1'b0;
      w_rd_issue  = 1'b0;
      w_rd_last   = 1'b0;
      mem_en      = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      case (r_state)
         IDLE: begin
            if (w_req_ok) begin
               w_state_nxt = PREFETCH;
               w_base_nxt  = w_line_base;
               w_col_nxt   = '0;
            end else if (!w_fifo_empty) begin
               w_fifo_pop = 1'b1;
               mem_en     = 1'b1;
               mem_we     = 1'b1;
               mem_addr   = w_fifo_dout[c_fifo_w-1:DATA_W];
               mem_wdata  = w_fifo_dout[DATA_W-1:0];
            end
         end
         PREFETCH: begin
            if (w_slot) begin
               w_fifo_pop = 1'b1;
               mem_en     = 1'b1;
               mem_we     = 1'b1;
               mem_addr   = w_fifo_dout[c_fifo_w-1:DATA_W];
               mem_wdata  = w_fifo_dout[DATA_W-1:0];
            end else begin
               mem_en     = 1'b1;
               mem_addr   = r_base + ADDR_W'(r_col);
               w_rd_issue = 1'b1;
               w_col_nxt  = r_col + 9'd1;
               if (r_col == c_last_col) begin
                  w_rd_last   = 1'b1;
                  w_state_nxt = DRAIN;
               end
            end
         end
         DRAIN:   w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_50 or negedge n_rst) begin
      if (!n_rst) begin
         r_state   <= IDLE;
         r_base    <= '0;
         r_col     <= '0;
         r_overrun <= 1'b0;
         r_rd_vld  <= 1'b0;
         r_rd_col  <= '0;
         r_rd_last <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_base    <= w_base_nxt;
         r_col     <= w_col_nxt;
         if (line_req && (r_state != IDLE)) r_overrun <= 1'b1;
         // read data returns one cycle after issue; tag it with its column
         r_rd_vld  <= w_rd_issue;
         r_rd_col  <= r_col;
         r_rd_last <= w_rd_last;
      end
   end

   assign lb_wen    = r_rd_vld;
   assign lb_waddr  = r_rd_col;
   assign lb_wdata  = r_rd_vld ? mem_rdata : '0;
   assign line_done = r_rd_last;
   assign overrun   = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_fb_mem_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_fb_mem_arbiter
// Purpose  : Directed self-checking bench for fb_mem_arbiter with an SRAM model
//            whose unwritten words read back their own address.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_fb_mem_arbiter;

   localparam int ADDR_W = 17;
   localparam int DATA_W = 24;
   localparam int WIDTH  = 320;

   logic              clk_50 = 1'b0;
   logic              n_rst;
   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              line_req;
   logic [7:0]        line_y;
   logic              lb_wen;
   logic [8:0]        lb_waddr;
   logic [DATA_W-1:0] lb_wdata;
   logic              line_done;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              overrun;

   fb_mem_arbiter dut (
      .clk_50    (clk_50),
      .n_rst     (n_rst),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .line_req  (line_req),
      .line_y    (line_y),
      .lb_wen    (lb_wen),
      .lb_waddr  (lb_waddr),
      .lb_wdata  (lb_wdata),
      .line_done (line_done),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .overrun   (overrun)
   );

   always #10 clk_50 = ~clk_50;

   // SRAM model: unwritten words return their address
   logic [DATA_W-1:0] sram   [1 << ADDR_W];
   bit                sram_v [1 << ADDR_W];

   always @(posedge clk_50) begin
      if (mem_en) begin
         if (mem_we) begin
            sram[mem_addr]   <= mem_wdata;
            sram_v[mem_addr] <= 1'b1;
         end else begin
            mem_rdata <= sram_v[mem_addr] ? sram[mem_addr] : DATA_W'(mem_addr);
         end
      end
   end

   int cyc;
   always @(posedge clk_50) cyc <= cyc + 1;

   // monitor
   int   exp_base;
   int   lb_cnt, lb_bad, lb_idx, done_cnt, done_cyc;
   int   rd_cnt, rd_oob, rd_first, rd_last, first_rd_cyc;
   logic prev_rd;
   int   wq_addr[$];
   int   wq_data[$];
   int   wq_cyc[$];

   always @(negedge clk_50) begin
      if (!n_rst) begin
         lb_idx  = 0;
         prev_rd = 1'b0;
      end else begin
         if (lb_wen) begin
            lb_cnt++;
            if (int'(lb_waddr) != lb_idx || int'(lb_wdata) != exp_base + lb_idx) lb_bad++;
            lb_idx++;
         end
         if (line_done) begin
            done_cnt++;
            done_cyc = cyc;
            lb_idx   = 0;
         end
         if (mem_en && !mem_we) begin
            rd_cnt++;
            if (!prev_rd) begin
               rd_first     = int'(mem_addr);
               first_rd_cyc = cyc;
            end
            rd_last = int'(mem_addr);
            if (int'(mem_addr) < exp_base || int'(mem_addr) > exp_base + WIDTH - 1) rd_oob++;
         end
         prev_rd = mem_en && !mem_we;
         if (mem_en && mem_we) begin
            wq_addr.push_back(int'(mem_addr));
            wq_data.push_back(int'(mem_wdata));
            wq_cyc.push_back(cyc);
         end
      end
   end

   int n_vec;
   int n_err;
   int t_req;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic pulse_line(input int y);
      line_y   = 8'(y);
      line_req = 1'b1;
      t_req    = cyc;
      @(posedge clk_50);
      #1;
      line_req = 1'b0;
   endtask

   task automatic wait_done(input int d0, input int limit);
      for (int i = 0; i < limit && done_cnt == d0; i++) @(posedge clk_50);
      #1;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk_50);
      #1;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int l0, b0, d0, r0, o0, q0, t1, n;
      n_rst = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
      line_req = 1'b0; line_y = '0; exp_base = 0;
      step(3);
      check("rst_wr_ready", wr_ready, 1);
      check("rst_outputs", {mem_en, mem_we, lb_wen, line_done, overrun}, 0);
      check("rst_mem_addr", mem_addr, 0);
      n_rst = 1'b1;
      step(2);

      // line 0
      exp_base = 0; l0 = lb_cnt; b0 = lb_bad; d0 = done_cnt;
      pulse_line(0);
      wait_done(d0, 400);
      check("l0_lb_count", lb_cnt - l0, WIDTH);
      check("l0_lb_data", lb_bad - b0, 0);
      check("l0_done", done_cnt - d0, 1);
      check("l0_done_latency", done_cyc - t_req, WIDTH + 1);
      check("l0_first_rd_latency", first_rd_cyc - t_req, 1);
      check("l0_first_addr", rd_first, 0);
      check("l0_last_addr", rd_last, WIDTH - 1);
      step(3);

      // last line
      exp_base = 76480; l0 = lb_cnt; b0 = lb_bad; d0 = done_cnt; o0 = rd_oob;
      pulse_line(239);
      wait_done(d0, 400);
      check("l239_first_addr", rd_first, 76480);
      check("l239_last_addr", rd_last, 76799);
      check("l239_oob_reads", rd_oob - o0, 0);
      check("l239_lb_count", lb_cnt - l0, WIDTH);
      check("l239_lb_data", lb_bad - b0, 0);
      step(3);

      // five writes during a prefetch
      exp_base = 1600; l0 = lb_cnt; b0 = lb_bad; d0 = done_cnt; q0 = wq_addr.size();
      pulse_line(5);
      step(10);
      for (int i = 0; i < 5; i++) begin
         wr_valid = 1'b1;
         wr_addr  = ADDR_W'(1000 + i);
         wr_data  = DATA_W'(24'hA50000 + i);
         for (int k = 0; k < 600 && !wr_ready; k++) step(1);
         step(1);
         if (i == 3) check("wr_full_after_4", wr_ready, 0);
      end
      wr_valid = 1'b0;
      wait_done(d0, 400);
      step(10);
      check("wr_count", wq_addr.size() - q0, 5);
      if (wq_addr.size() >= q0 + 5) begin
         for (int i = 0; i < 5; i++) begin
            check($sformatf("wr%0d_addr", i), wq_addr[q0 + i], 1000 + i);
            check($sformatf("wr%0d_data", i), wq_data[q0 + i], 24'hA50000 + i);
         end
`ifndef FB_WRITE_SLOT_EN
         check("wr_after_drain", wq_cyc[q0] == done_cyc + 1, 1);
`endif
      end
      check("wr_line_lb_count", lb_cnt - l0, WIDTH);
      check("wr_line_lb_data", lb_bad - b0, 0);

      // second request mid-prefetch
      exp_base = 3200; l0 = lb_cnt; b0 = lb_bad; d0 = done_cnt; o0 = rd_oob;
      pulse_line(10);
      t1 = t_req;
      step(99);
      pulse_line(20);
      check("ovr_set", overrun, 1);
      wait_done(d0, 400);
      step(40);
      check("ovr_done_count", done_cnt - d0, 1);
      check("ovr_lb_count", lb_cnt - l0, WIDTH);
      check("ovr_lb_data", lb_bad - b0, 0);
      check("ovr_oob_reads", rd_oob - o0, 0);
      check("ovr_done_latency", done_cyc - t1, WIDTH + 1);
      check("ovr_sticky", overrun, 1);

      // reset in the middle of a prefetch
      exp_base = 320;
      pulse_line(1);
      step(50);
      n_rst = 1'b0;
      #1;
      check("midrst_quiet", {lb_wen, line_done, mem_en, overrun}, 0);
      check("midrst_wr_ready", wr_ready, 1);
      l0 = lb_cnt; d0 = done_cnt;
      step(2);
      n_rst = 1'b1;
      step(20);
      check("midrst_no_lb", lb_cnt - l0, 0);
      check("midrst_no_done", done_cnt - d0, 0);

      // out-of-range line
      r0 = rd_cnt; d0 = done_cnt;
      pulse_line(240);
      step(20);
      check("y240_no_reads", rd_cnt - r0, 0);
      check("y240_no_done", done_cnt - d0, 0);
      check("y240_no_overrun", overrun, 0);

      // out-of-range write address is passed through
      q0 = wq_addr.size();
      wr_valid = 1'b1; wr_addr = ADDR_W'(100000); wr_data = 24'h123456;
      step(1);
      wr_valid = 1'b0;
      step(3);
      check("oor_wr_count", wq_addr.size() - q0, 1);
      if (wq_addr.size() > q0) check("oor_wr_addr", wq_addr[q0], 100000);

`ifdef FB_WRITE_SLOT_EN
      // keep the FIFO topped up across a prefetch
      exp_base = 32000; l0 = lb_cnt; b0 = lb_bad; d0 = done_cnt; q0 = wq_addr.size();
      n = 0;
      wr_valid = 1'b1; wr_addr = ADDR_W'(2000); wr_data = 24'h5A0000;
      line_y = 8'd100; line_req = 1'b1; t_req = cyc;
      for (int k = 0; k < 500 && done_cnt == d0; k++) begin
         logic acc;
         acc = wr_valid && wr_ready;
         step(1);
         line_req = 1'b0;
         if (acc) begin
            n++;
            wr_addr = ADDR_W'(2000 + n);
            wr_data = DATA_W'(24'h5A0000 + n);
            if (n == 40) wr_valid = 1'b0;
         end
      end
      wr_valid = 1'b0;
      begin
         int in_pf;
         in_pf = 0;
         foreach (wq_cyc[i]) if (i >= q0 && wq_cyc[i] > t_req && wq_cyc[i] < done_cyc) in_pf++;
         check("slot_writes_in_prefetch", in_pf >= 2, 1);
      end
      check("slot_lb_count", lb_cnt - l0, WIDTH);
      check("slot_lb_data", lb_bad - b0, 0);
      check("slot_done_latency", (done_cyc - t_req > WIDTH + 1) && (done_cyc - t_req <= WIDTH + 21), 1);
      step(60);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
